// File: rtl/word_transmitter_pkg.sv
// Shared encodings for the word transmitter and word receiver:
// Tipo codes, note-bus symbols, seven-segment patterns, FSM states.
package word_transmitter_pkg;

  typedef logic [1:0] tipo_t;
  typedef logic [3:0] sym_t;
  typedef logic [6:0] seg_t;

  localparam tipo_t TIPO_DO   = 2'b11;
  localparam tipo_t TIPO_RE   = 2'b10;
  localparam tipo_t TIPO_MI   = 2'b01;
  localparam tipo_t TIPO_NONE = 2'b00;

  localparam sym_t SYM_DO   = 4'b0011;
  localparam sym_t SYM_RE   = 4'b0100;
  localparam sym_t SYM_MI   = 4'b0101;
  localparam sym_t SYM_TERM = 4'b0000;

  localparam seg_t SEG_DO    = 7'b1000010;
  localparam seg_t SEG_RE    = 7'b1111010;
  localparam seg_t SEG_MI    = 7'b0001001;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LETTER = 2'd1;
  localparam logic [1:0] ST_TERM   = 2'd2;

endpackage

// File: rtl/symbol_encoder.sv
// Maps a Tipo code to its note-bus symbol and seven-segment pattern.
// TIPO_NONE yields the terminator and a blank display.
module symbol_encoder
  import word_transmitter_pkg::*;
(
  input  logic [1:0] tipo_i,
  output logic [3:0] sym_o,
  output logic [6:0] seg_o
);

  always_comb begin
    sym_o = SYM_TERM;
    seg_o = SEG_BLANK;
    unique case (1'b1)
      tipo_i == TIPO_DO: begin
        sym_o = SYM_DO;
        seg_o = SEG_DO;
      end
      tipo_i == TIPO_RE: begin
        sym_o = SYM_RE;
        seg_o = SEG_RE;
      end
      tipo_i == TIPO_MI: begin
        sym_o = SYM_MI;
        seg_o = SEG_MI;
      end
      default: begin
        sym_o = SYM_TERM;
        seg_o = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: rtl/word_transmitter.sv
// Sends one letter word as LETTER then TERM on the note bus,
// with a 1-deep pending slot so back-to-back words have no gap.
module word_transmitter
  import word_transmitter_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Tipo_in,
  output logic       Ack,
  output logic       Reject,
  output logic       Tom,
  output logic       Nota_A,
  output logic       Nota_B,
  output logic       Nota_C,
  output logic       Ready,
  output logic       End,
  output logic       Busy,
  output logic [6:0] Saida
);

  localparam logic [3:0] LAST = 4'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  tipo_t      cur_q, cur_d;
  tipo_t      pend_q, pend_d;
  logic       pvld_q, pvld_d;

  logic       accept, reject;
  logic       take;
  tipo_t      enc_tipo;
  sym_t       enc_sym;
  seg_t       enc_seg;
  logic       end_d;

  logic [3:0] bus_q;
  seg_t       seg_q;
  logic       ack_q, rej_q, end_q;
  logic       busy_q, ready_q;

  assign accept = Start && (Tipo_in != TIPO_NONE) && !pvld_q;
  assign reject = Start && !accept;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pvld_q) begin
          state_d = ST_LETTER;
          take    = 1'b1;
        end
      end
      ST_LETTER: begin
        if (cnt_q == LAST) state_d = ST_TERM;
      end
      ST_TERM: begin
        if (cnt_q == LAST) begin
          if (pvld_q) begin
            state_d = ST_LETTER;
            take    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = 4'd0;
    else if (state_q != ST_IDLE && cnt_q != LAST) cnt_d = cnt_q + 4'd1;
  end

  // The slot is consumed by take and refilled only when it was empty,
  // so the two never collide in one cycle.
  always_comb begin
    cur_d  = cur_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    if (take) begin
      cur_d  = pend_q;
      pvld_d = 1'b0;
    end
    if (accept) begin
      pend_d = Tipo_in;
      pvld_d = 1'b1;
    end
  end

  assign enc_tipo = (state_d == ST_LETTER) ? cur_d : TIPO_NONE;
  assign end_d    = (state_d == ST_TERM) && (cnt_d == LAST);

  symbol_encoder u_enc (
    .tipo_i (enc_tipo),
    .sym_o  (enc_sym),
    .seg_o  (enc_seg)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cur_q   <= TIPO_NONE;
      pend_q  <= TIPO_NONE;
      pvld_q  <= 1'b0;
      bus_q   <= SYM_TERM;
      seg_q   <= SEG_BLANK;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      bus_q   <= enc_sym;
      seg_q   <= enc_seg;
      ack_q   <= accept;
      rej_q   <= reject;
      end_q   <= end_d;
      busy_q  <= state_d != ST_IDLE;
      ready_q <= state_d != ST_IDLE;
    end
  end

  assign {Tom, Nota_A, Nota_B, Nota_C} = bus_q;
  assign Saida  = seg_q;
  assign Ack    = ack_q;
  assign Reject = rej_q;
  assign End    = end_q;
  assign Busy   = busy_q;
  assign Ready  = ready_q;

endmodule

// File: tb/tb_word_transmitter.sv
// Directed bench for word_transmitter with HOLD_CYCLES=4.
// Index k of a stimulus table is sampled at edge k; logs hold outputs after it.
module tb_word_transmitter;

  logic       clk = 1'b0;
  logic       Reset, Start;
  logic [1:0] Tipo_in;
  logic       Ack, Reject, Tom, Nota_A, Nota_B, Nota_C;
  logic       Ready, End, Busy;
  logic [6:0] Saida;

  int n_chk = 0;
  int n_err = 0;

  logic       s_r[32];
  logic       s_s[32];
  logic [1:0] s_t[32];
  logic [3:0] l_bus[32];
  logic [6:0] l_seg[32];
  logic       l_ack[32], l_rej[32], l_end[32];
  logic       l_busy[32], l_rdy[32];

  word_transmitter #(.HOLD_CYCLES(4)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .Start   (Start),
    .Tipo_in (Tipo_in),
    .Ack     (Ack),
    .Reject  (Reject),
    .Tom     (Tom),
    .Nota_A  (Nota_A),
    .Nota_B  (Nota_B),
    .Nota_C  (Nota_C),
    .Ready   (Ready),
    .End     (End),
    .Busy    (Busy),
    .Saida   (Saida)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 32; k++) begin
      s_r[k] = 1'b0;
      s_s[k] = 1'b0;
      s_t[k] = 2'b00;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Tipo_in = 2'b00;
    @(posedge clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      Reset   = s_r[k];
      Start   = s_s[k];
      Tipo_in = s_t[k];
      @(posedge clk);
      #1;
      l_bus[k]  = {Tom, Nota_A, Nota_B, Nota_C};
      l_seg[k]  = Saida;
      l_ack[k]  = Ack;
      l_rej[k]  = Reject;
      l_end[k]  = End;
      l_busy[k] = Busy;
      l_rdy[k]  = Ready;
    end
    Reset = 1'b0;
    Start = 1'b0;
    Tipo_in = 2'b00;
  endtask

  function automatic logic [1:0] rx_decode(input logic [3:0] sym);
    case (sym)
      4'b0011: return 2'b11;
      4'b0100: return 2'b10;
      4'b0101: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  logic [1:0] tv[3];
  logic [6:0] sv[3];
  logic [1:0] rx;

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Tipo_in = 2'b00;

    // reset values
    do_reset();
    check("rst_bus", {Tom, Nota_A, Nota_B, Nota_C}, 4'b0000);
    check("rst_seg", Saida, 7'b1111111);
    check("rst_ack", Ack, 0);
    check("rst_rej", Reject, 0);
    check("rst_end", End, 0);
    check("rst_busy", Busy, 0);
    check("rst_rdy", Ready, 0);

    // single Do word
    clr();
    s_s[0] = 1'b1; s_t[0] = 2'b11;
    run(12);
    check("w1_ack0", l_ack[0], 1);
    check("w1_busy0", l_busy[0], 0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("w1_bus@%0d", k), l_bus[k], 4'b0011);
      check($sformatf("w1_seg@%0d", k), l_seg[k], 7'b1000010);
    end
    for (int k = 5; k <= 8; k++) begin
      check($sformatf("w1_term@%0d", k), l_bus[k], 4'b0000);
      check($sformatf("w1_blank@%0d", k), l_seg[k], 7'b1111111);
    end
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("w1_busy@%0d", k), l_busy[k], 1);
      check($sformatf("w1_rdy@%0d", k), l_rdy[k], 1);
      check($sformatf("w1_end@%0d", k), l_end[k], k == 8);
    end
    check("w1_busy9", l_busy[9], 0);
    check("w1_rdy9", l_rdy[9], 0);
    check("w1_end9", l_end[9], 0);
    check("w1_seg9", l_seg[9], 7'b1111111);

    // illegal Tipo
    do_reset();
    clr();
    s_s[0] = 1'b1; s_t[0] = 2'b00;
    run(4);
    check("ill_rej0", l_rej[0], 1);
    check("ill_ack0", l_ack[0], 0);
    check("ill_busy1", l_busy[1], 0);
    check("ill_rdy1", l_rdy[1], 0);
    check("ill_rej1", l_rej[1], 0);

    // back-to-back with pending slot, then full-slot reject
    do_reset();
    clr();
    s_s[0] = 1'b1; s_t[0] = 2'b10;
    s_s[2] = 1'b1; s_t[2] = 2'b01;
    s_s[3] = 1'b1; s_t[3] = 2'b11;
    run(20);
    check("bb_ack0", l_ack[0], 1);
    check("bb_ack2", l_ack[2], 1);
    check("bb_rej3", l_rej[3], 1);
    check("bb_ack3", l_ack[3], 0);
    check("bb_bus1", l_bus[1], 4'b0100);
    check("bb_seg1", l_seg[1], 7'b1111010);
    check("bb_end8", l_end[8], 1);
    for (int k = 9; k <= 12; k++) begin
      check($sformatf("bb_mi@%0d", k), l_bus[k], 4'b0101);
      check($sformatf("bb_miseg@%0d", k), l_seg[k], 7'b0001001);
    end
    check("bb_term13", l_bus[13], 4'b0000);
    for (int k = 1; k <= 16; k++)
      check($sformatf("bb_busy@%0d", k), l_busy[k], 1);
    check("bb_end16", l_end[16], 1);
    check("bb_busy17", l_busy[17], 0);

    // pending slot full on the End cycle -> reject
    do_reset();
    clr();
    s_s[0] = 1'b1; s_t[0] = 2'b10;
    s_s[2] = 1'b1; s_t[2] = 2'b01;
    s_s[8] = 1'b1; s_t[8] = 2'b11;
    run(20);
    check("pe_end8", l_end[8], 1);
    check("pe_rej8", l_rej[8], 1);
    check("pe_ack8", l_ack[8], 0);
    check("pe_bus9", l_bus[9], 4'b0101);
    check("pe_end16", l_end[16], 1);
    check("pe_busy17", l_busy[17], 0);

    // empty slot on the End cycle -> next word with no gap
    do_reset();
    clr();
    s_s[0] = 1'b1; s_t[0] = 2'b11;
    s_s[8] = 1'b1; s_t[8] = 2'b10;
    run(12);
    check("ne_end8", l_end[8], 1);
    check("ne_ack8", l_ack[8], 1);
    check("ne_rej8", l_rej[8], 0);
    check("ne_bus9", l_bus[9], 4'b0100);
    check("ne_busy9", l_busy[9], 1);
    check("ne_rdy9", l_rdy[9], 1);

    // reset mid-word; Start during reset ignored
    do_reset();
    clr();
    s_s[0] = 1'b1; s_t[0] = 2'b11;
    s_r[3] = 1'b1;
    s_s[3] = 1'b1; s_t[3] = 2'b10;
    s_s[6] = 1'b1; s_t[6] = 2'b01;
    run(16);
    check("mr_bus2", l_bus[2], 4'b0011);
    check("mr_bus3", l_bus[3], 4'b0000);
    check("mr_seg3", l_seg[3], 7'b1111111);
    check("mr_busy3", l_busy[3], 0);
    check("mr_rdy3", l_rdy[3], 0);
    check("mr_ack3", l_ack[3], 0);
    check("mr_rej3", l_rej[3], 0);
    for (int k = 3; k <= 6; k++)
      check($sformatf("mr_end@%0d", k), l_end[k], 0);
    check("mr_busy5", l_busy[5], 0);
    check("mr_ack6", l_ack[6], 1);
    check("mr_bus7", l_bus[7], 4'b0101);
    check("mr_busy7", l_busy[7], 1);

    // loopback through a receiver model for every Tipo
    tv[0] = 2'b11; sv[0] = 7'b1000010;
    tv[1] = 2'b10; sv[1] = 7'b1111010;
    tv[2] = 2'b01; sv[2] = 7'b0001001;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      clr();
      s_s[0] = 1'b1; s_t[0] = tv[i];
      run(10);
      rx = 2'b00;
      for (int k = 0; k < 10; k++)
        if (l_rdy[k] && l_bus[k] != 4'b0000) rx = rx_decode(l_bus[k]);
      check($sformatf("lb_tipo%0d", i), rx, tv[i]);
      check($sformatf("lb_seg%0d", i), l_seg[2], sv[i]);
      check($sformatf("lb_end%0d", i), l_end[8], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
